// File: rtl/aes_out_buffer.sv
// Result FIFO behind the AES-128 datapath: captures offloaded ciphertexts, presents them on a
// valid/ready port and tracks in-flight pairs so admission never outruns free FIFO space.
module aes_out_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          init,
  input  logic          add_track,
  input  logic          sub_track,
  input  logic [127:0]  cipher_text,
  input  logic [3:0]    pair_id,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [127:0]  out_data,
  output logic [3:0]    out_id,
  output logic [CW-1:0] count,
  output logic [CW-1:0] inflight,
  output logic          admit_ok,
  output logic          overflow,
  output logic          id_err
);

  localparam int unsigned   AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW:0]   DepthW = (CW + 1)'(DEPTH);

  logic [131:0]  mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] count_q, count_d, inflight_q, inflight_d;
  logic          overflow_q, overflow_d, id_err_q, id_err_d;
  logic          full, pop, push, id_bad;
  logic [CW:0]   occupancy;

  always_comb begin
    full   = (count_q == DepthC);
    pop    = (count_q != '0) && out_ready;
    // A pop in the same cycle frees the head slot, so a push at full is still accepted.
    push   = sub_track && (!full || pop);
    id_bad = (pair_id == 4'd0) || (pair_id > 4'd4);

    wp_d = push ? wp_q + AW'(1) : wp_q;
    rp_d = pop  ? rp_q + AW'(1) : rp_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    inflight_d = inflight_q;
    if (add_track && !sub_track && (inflight_q != DepthC)) begin
      inflight_d = inflight_q + CW'(1);
    end else if (sub_track && !add_track && (inflight_q != '0)) begin
      inflight_d = inflight_q - CW'(1);
    end

    overflow_d = overflow_q | (sub_track && full && !pop);
    id_err_d   = id_err_q | (sub_track && (id_bad || (inflight_q == '0)));
  end

  always_ff @(posedge clk) begin
    if (init) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      overflow_q <= 1'b0;
      id_err_q   <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      overflow_q <= overflow_d;
      id_err_q   <= id_err_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once count is cleared.
  always_ff @(posedge clk) begin
    if (!init && push) begin
      mem[wp_q] <= {cipher_text, pair_id};
    end
  end

  assign {out_data, out_id} = mem[rp_q];
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign inflight  = inflight_q;
  assign occupancy = {1'b0, count_q} + {1'b0, inflight_q};
  assign admit_ok  = (occupancy < DepthW);
  assign overflow  = overflow_q;
  assign id_err    = id_err_q;

endmodule

// File: tb/tb_aes_out_buffer.sv
// Self-checking bench for aes_out_buffer: directed vector table, corner-case sequences and
// randomized traffic against a queue-based reference model.
module tb_aes_out_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [127:0] K    = 128'h3925841d02dc09fbdc118597196a0b32;

  logic          clk = 1'b0;
  logic          init, add_track, sub_track, out_ready;
  logic [127:0]  cipher_text;
  logic [3:0]    pair_id;
  logic          out_valid, admit_ok, overflow, id_err;
  logic [127:0]  out_data;
  logic [3:0]    out_id;
  logic [CW-1:0] count, inflight;

  always #5 clk = ~clk;

  aes_out_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .init       (init),
    .add_track  (add_track),
    .sub_track  (sub_track),
    .cipher_text(cipher_text),
    .pair_id    (pair_id),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .count      (count),
    .inflight   (inflight),
    .admit_ok   (admit_ok),
    .overflow   (overflow),
    .id_err     (id_err)
  );

  typedef struct packed {
    logic [127:0] d;
    logic [3:0]   tag;
  } ent_t;

  // Reference model: FIFO contents as a queue plus plain counters/flags.
  ent_t mq[$];
  int   m_inf;
  bit   m_ovf, m_err;

  int n_run  = 0;
  int n_fail = 0;

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic i_init, input logic a, input logic s, input logic r,
                       input logic [3:0] id, input logic [127:0] ct);
    bit mpop;
    init = i_init; add_track = a; sub_track = s; out_ready = r;
    pair_id = id; cipher_text = ct;
    if (i_init) begin
      mq.delete(); m_inf = 0; m_ovf = 0; m_err = 0;
    end else begin
      mpop = r && (mq.size() != 0);
      if (s && (id < 1 || id > 4 || m_inf == 0)) m_err = 1;
      if (mpop) void'(mq.pop_front());
      if (s) begin
        if (mq.size() < DEPTH) mq.push_back({ct, id});
        else m_ovf = 1;
      end
      if (a && !s && m_inf < DEPTH) m_inf++;
      else if (s && !a && m_inf > 0) m_inf--;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_model(input string tag);
    cmp({tag, ".count"}, 128'(count), 128'(mq.size()));
    cmp({tag, ".inflight"}, 128'(inflight), 128'(m_inf));
    cmp({tag, ".valid"}, 128'(out_valid), 128'(mq.size() != 0));
    cmp({tag, ".admit"}, 128'(admit_ok), 128'((mq.size() + m_inf) < DEPTH));
    cmp({tag, ".ovf"}, 128'(overflow), 128'(m_ovf));
    cmp({tag, ".err"}, 128'(id_err), 128'(m_err));
    if (mq.size() != 0) begin
      cmp({tag, ".data"}, out_data, mq[0].d);
      cmp({tag, ".id"}, 128'(out_id), 128'(mq[0].tag));
    end
  endtask

  typedef struct {
    logic         i_init, a, s, r;
    logic [3:0]   id;
    logic [127:0] ct;
    int           e_count, e_inf;
    logic         e_valid, e_admit;
    logic [3:0]   e_id;
    logic [127:0] e_data;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [127:0] d2, d3, d4, dn, dx;
    d2 = {32{4'h2}}; d3 = {32{4'h3}}; d4 = {32{4'h4}};
    dn = 128'hfeed_0000_0000_0000_0000_0000_0000_beef;
    dx = 128'hdead_dead_dead_dead_dead_dead_dead_dead;
    init = 1'b0; add_track = 1'b0; sub_track = 1'b0; out_ready = 1'b0;
    pair_id = 4'd0; cipher_text = '0;
    m_inf = 0; m_ovf = 0; m_err = 0;

    // init add sub rdy id ct | count inf valid admit id data
    tbl[0]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0};
    tbl[2]  = '{0, 0, 1, 0, 1, K,  1, 0, 1, 1, 1, K};
    tbl[3]  = '{0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 0,  0, 2, 0, 1, 0, 0};
    tbl[6]  = '{0, 1, 0, 0, 0, 0,  0, 3, 0, 1, 0, 0};
    tbl[7]  = '{0, 1, 0, 0, 0, 0,  0, 4, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 1, 0, 1, K,  1, 3, 1, 0, 1, K};
    tbl[9]  = '{0, 0, 1, 0, 2, d2, 2, 2, 1, 0, 1, K};
    tbl[10] = '{0, 0, 1, 0, 3, d3, 3, 1, 1, 0, 1, K};
    tbl[11] = '{0, 0, 1, 0, 4, d4, 4, 0, 1, 0, 1, K};
    tbl[12] = '{0, 0, 0, 1, 0, 0,  3, 0, 1, 1, 2, d2};
    tbl[13] = '{0, 0, 0, 1, 0, 0,  2, 0, 1, 1, 3, d3};
    tbl[14] = '{0, 0, 0, 1, 0, 0,  1, 0, 1, 1, 4, d4};
    tbl[15] = '{0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 0};

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].i_init, tbl[i].a, tbl[i].s, tbl[i].r, tbl[i].id, tbl[i].ct);
      cmp($sformatf("vec%0d.count", i), 128'(count), 128'(tbl[i].e_count));
      cmp($sformatf("vec%0d.inflight", i), 128'(inflight), 128'(tbl[i].e_inf));
      cmp($sformatf("vec%0d.valid", i), 128'(out_valid), 128'(tbl[i].e_valid));
      cmp($sformatf("vec%0d.admit", i), 128'(admit_ok), 128'(tbl[i].e_admit));
      cmp($sformatf("vec%0d.ovf", i), 128'(overflow), 128'(0));
      cmp($sformatf("vec%0d.err", i), 128'(id_err), 128'(0));
      if (tbl[i].e_valid) begin
        cmp($sformatf("vec%0d.id", i), 128'(out_id), 128'(tbl[i].e_id));
        cmp($sformatf("vec%0d.data", i), out_data, tbl[i].e_data);
      end
    end

    // Push and pop together at full: count holds, new entry exits last.
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cycle(0, 0, 1, 0, 4'(i), {32{4'(i)}});
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 1, dn);
    cmp("fullpp.count", 128'(count), 128'(4));
    cmp("fullpp.ovf", 128'(overflow), 128'(0));
    check_model("fullpp");
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, 0, 0);
      check_model("fullpp_drain");
    end
    cmp("fullpp.last", out_data, dn);
    cycle(0, 0, 0, 1, 0, 0);
    check_model("fullpp_empty");

    // Forced overflow: fifth result while full and stalled is dropped.
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 1, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 4'(i), {32{4'(i)}} ^ 128'h5a);
    end
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 2, dx);
    cmp("ovf.flag", 128'(overflow), 128'(1));
    cmp("ovf.count", 128'(count), 128'(4));
    for (int i = 0; i < 4; i++) begin
      cmp("ovf.nodrop", 128'(out_data == dx), 128'(0));
      cycle(0, 0, 0, 1, 0, 0);
      check_model("ovf_drain");
    end
    cmp("ovf.sticky", 128'(overflow), 128'(1));

    // Illegal ID, offload with nothing in flight, reset mid-operation.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 4'hf, K);
    cmp("err.badid", 128'(id_err), 128'(1));
    cmp("err.stored", 128'(count), 128'(1));
    cycle(0, 0, 1, 0, 2, d2);
    cmp("err.zero_err", 128'(id_err), 128'(1));
    cmp("err.zero_inf", 128'(inflight), 128'(0));
    check_model("err");
    cycle(0, 0, 1, 0, 3, d3);
    cycle(0, 1, 0, 0, 0, 0);
    cmp("rst.pre", 128'(count), 128'(3));
    cycle(1, 1, 1, 1, 1, K);
    cmp("rst.valid", 128'(out_valid), 128'(0));
    cmp("rst.count", 128'(count), 128'(0));
    cmp("rst.inflight", 128'(inflight), 128'(0));
    cmp("rst.admit", 128'(admit_ok), 128'(1));
    cmp("rst.ovf", 128'(overflow), 128'(0));
    cmp("rst.err", 128'(id_err), 128'(0));

    // Pointer wrap with interleaved push/pop.
    cycle(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 1, i[0], 4'((i % 4) + 1), 128'(i) * 128'h1_0001);
      check_model("wrap");
      cmp("wrap.max", 128'(count <= 4), 128'(1));
    end

    // Randomized traffic.
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic [3:0] rid;
      rid = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      cycle(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 1'($urandom), rid,
            {$urandom, $urandom, $urandom, $urandom});
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
